// File: rtl/mac_pkg.sv
// Shared defaults and helpers for the multiply-accumulate unit.
package mac_pkg;

  localparam int unsigned DefInW  = 8;
  localparam int unsigned DefAccW = 16;

  // All-ones value of the given accumulator width, used as the saturation clamp.
  // Valid for widths 1..64; callers size-cast the result down to their width.
  function automatic logic [63:0] max_acc(input int unsigned acc_w);
    return {64{1'b1}} >> (64 - acc_w);
  endfunction

endpackage

// File: rtl/mac_mult.sv
// Combinational unsigned IN_W x IN_W multiplier with a full-width product.
// Kept separate so it can be swapped for a DSP-mapped or pipelined variant.
module mac_mult #(
  parameter int unsigned IN_W = 8
) (
  input  logic [IN_W-1:0]   a_i,
  input  logic [IN_W-1:0]   b_i,
  output logic [2*IN_W-1:0] prod_o
);

  // Widen both operands first so no product bits are lost.
  assign prod_o = (2*IN_W)'(a_i) * (2*IN_W)'(b_i);

endmodule

// File: rtl/mac.sv
// Unsigned multiply-accumulate: acc += opa * opb on every rising clk edge.
// The accumulator drives out directly; clr clears it asynchronously.
module mac
  import mac_pkg::*;
#(
  parameter int unsigned IN_W     = DefInW,
  parameter int unsigned ACC_W    = DefAccW,  // must be >= 2*IN_W
  parameter bit          SATURATE = 1'b0
) (
  output logic [ACC_W-1:0] out,
  input  logic [IN_W-1:0]  opa,
  input  logic [IN_W-1:0]  opb,
  input  logic             clk,
  input  logic             clr
);

  localparam logic [ACC_W-1:0] AccMax = ACC_W'(max_acc(ACC_W));

  logic [2*IN_W-1:0] prod;
  logic [ACC_W:0]    sum;
  logic [ACC_W-1:0]  acc_d, acc_q;

  mac_mult #(
    .IN_W (IN_W)
  ) u_mult (
    .a_i    (opa),
    .b_i    (opb),
    .prod_o (prod)
  );

  // One extra bit on the sum exposes the carry for the saturation decision.
  assign sum = {1'b0, acc_q} + (ACC_W+1)'(prod);

  // Next accumulator value: wrap by dropping the carry, or clamp on overflow.
  always_comb begin
    acc_d = sum[ACC_W-1:0];
    if (SATURATE && sum[ACC_W]) begin
      acc_d = AccMax;
    end
  end

  // Accumulator register; clr low clears immediately and holds it at zero.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign out = acc_q;

endmodule

// File: tb/tb_mac.sv
// Self-checking bench for mac: wrapping and saturating instances share stimulus
// and are checked against a plain-arithmetic model of the accumulator.
module tb_mac;

  logic        clk;
  logic        clr;
  logic [7:0]  opa;
  logic [7:0]  opb;
  logic [15:0] out_wrap;
  logic [15:0] out_sat;

  int unsigned m_wrap;
  int unsigned m_sat;
  int          n_pass;
  int          n_chk;

  mac #(
    .IN_W     (8),
    .ACC_W    (16),
    .SATURATE (1'b0)
  ) u_wrap (
    .out (out_wrap),
    .opa (opa),
    .opb (opb),
    .clk (clk),
    .clr (clr)
  );

  mac #(
    .IN_W     (8),
    .ACC_W    (16),
    .SATURATE (1'b1)
  ) u_sat (
    .out (out_sat),
    .opa (opa),
    .opb (opb),
    .clk (clk),
    .clr (clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_both(input string tag);
    check({tag, "/wrap"}, out_wrap, 16'(m_wrap));
    check({tag, "/sat"},  out_sat,  16'(m_sat));
  endtask

  // Apply operands, clock once, advance the model, then compare just after the edge.
  task automatic step(input int unsigned a, input int unsigned b, input string tag);
    opa = 8'(a);
    opb = 8'(b);
    @(posedge clk);
    #1;
    m_wrap = (m_wrap + a * b) % 65536;
    m_sat  = (m_sat + a * b > 65535) ? 65535 : m_sat + a * b;
    check_both(tag);
  endtask

  // Pulse clr low between edges; out must read zero before the next edge.
  task automatic clear_pulse(input string tag);
    #1 clr = 1'b0;
    #1;
    m_wrap = 0;
    m_sat  = 0;
    check_both(tag);
    #1 clr = 1'b1;
  endtask

  initial begin
    n_pass = 0;
    n_chk  = 0;
    m_wrap = 0;
    m_sat  = 0;
    clr    = 1'b0;
    opa    = 8'd5;
    opb    = 8'd7;

    // Held in reset: edges and operands must not disturb the zero accumulator.
    #2;
    check_both("reset_async");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_both("reset_hold");
    end

    // Release between edges; first accumulation on the next rising edge.
    clr = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step(i, 10, "basic");
    end
    check(out_wrap == 16'd550 ? "basic_end" : "basic_end", out_wrap, 16'd550);

    for (int i = 0; i < 3; i++) begin
      step(0, 200, "zero_opa");
    end
    step(3, 0, "zero_opb");

    clear_pulse("midclear_550");

    // Overflow: wrap gives 64514, saturate clamps and sticks at all-ones.
    step(255, 255, "ovf1");
    check("ovf1_const", out_wrap, 16'd65025);
    step(255, 255, "ovf2");
    check("wrap_const", out_wrap, 16'd64514);
    check("sat_const", out_sat, 16'd65535);
    step(1, 1, "sat_sticky");
    check("sat_sticky_const", out_sat, 16'd65535);

    clear_pulse("clear_after_sat");

    // Mid-stream clear must leave no residue of the earlier sum.
    step(15, 20, "acc300");
    clear_pulse("midclear_300");
    step(2, 3, "after_clear");
    check("after_clear_const", out_wrap, 16'd6);

    // Randomized run, with large operands often enough to hit overflow.
    for (int i = 0; i < 300; i++) begin
      int unsigned a;
      int unsigned b;
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      if ($urandom_range(0, 9) == 0) a = 0;
      step(a, b, "rand");
      if ($urandom_range(0, 40) == 0) clear_pulse("rand_clear");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
